// File: rtl/branch_resolve.sv
// branch_resolve -- execute-stage branch/jump resolution unit.
//
// Accepts one op per cycle from issue. The op is a fall-through, a conditional
// branch, JAL or JALR. The unit evaluates the branch condition and computes
// taken, target and the link value. Results go to writeback through a
// registered valid/ready output. A taken op with an aligned target raises a
// redirect to fetch, which is held until fetch accepts it.
//
// Every redirect toggles an epoch bit. Ops issued down the wrong path carry
// the old epoch, so the unit drops them silently (static predict-not-taken).
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    issue handshake
//   in_pc, in_imm        op PC and sign-extended immediate
//   in_rs1, in_rs2       operands
//   in_funct3, in_op     branch condition / op class (00 none, 01 br, 10 JAL, 11 JALR)
//   in_epoch, epoch      epoch tag of the offered op / current epoch
//   out_*                registered result toward writeback (valid/ready)
//   redir_*              redirect request toward fetch (valid/ready)
//
// Optional feature: define BRANCH_RESOLVE_STATS_EN to add the stat_branches
// and stat_taken counters as outputs.
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_op,
  input  logic            in_epoch,
  output logic            epoch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_rd_data,
  output logic            out_taken,
  output logic            out_misalign,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  typedef enum logic [1:0] {
    IDLE,   // nothing held
    HOLD,   // result waiting for writeback
    REDIR   // redirect pending; input blocked
  } state_e;

  state_e          state_q;
  logic            out_valid_q, out_valid_d;
  logic            redir_valid_q, redir_valid_d;
  logic            epoch_q, epoch_d;
  logic            out_rd_we_q, out_taken_q, out_misalign_q;
  logic [XLEN-1:0] out_rd_data_q, redir_pc_q;

  logic            accept, live;
  logic            is_br, is_jal, is_jalr;
  logic            eq, lt_s, lt_u, cond;
  logic            taken_d, redirect_d;
  logic [XLEN-1:0] target_d;

  // While a redirect is pending (REDIR), no op is accepted. In HOLD, an op is
  // accepted only if writeback takes the held result in the same cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  // A stale-epoch op is consumed from issue but has no other effect.
  assign live     = accept && (in_epoch == epoch_q);

  assign is_br   = (in_op == 2'b01);
  assign is_jal  = (in_op == 2'b10);
  assign is_jalr = (in_op == 2'b11);

  assign eq   = (in_rs1 == in_rs2);
  assign lt_s = ($signed(in_rs1) < $signed(in_rs2));
  assign lt_u = (in_rs1 < in_rs2);

  always_comb begin
    // NOTE: give every always_comb output a default first. Without it, any
    // path that does not assign the output infers a latch.
    cond = 1'b0;
    case (in_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;  // 010/011: never taken, not a fault
    endcase
  end

  assign target_d   = is_jalr ? ((in_rs1 + in_imm) & ~XLEN'(1)) : (in_pc + in_imm);
  assign taken_d    = is_jal || is_jalr || (is_br && cond);
  // A taken op whose target has bit 1 set is reported as misaligned. It
  // produces no redirect and leaves the epoch unchanged.
  assign redirect_d = taken_d && !target_d[1];

  always_comb begin
    out_valid_d   = out_valid_q;
    redir_valid_d = redir_valid_q;
    epoch_d       = epoch_q;
    if (redir_valid_q && redir_ready) redir_valid_d = 1'b0;
    if (out_valid_q && out_ready)     out_valid_d   = 1'b0;
    if (live) begin
      out_valid_d = 1'b1;
      if (redirect_d) begin
        redir_valid_d = 1'b1;
        epoch_d       = !epoch_q;
      end
    end
  end

  // NOTE: registers are written with non-blocking assignments only, so every
  // flop samples values from before the edge, whatever order the lines are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      redir_valid_q  <= 1'b0;
      epoch_q        <= 1'b0;
      out_rd_we_q    <= 1'b0;
      out_rd_data_q  <= '0;
      out_taken_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      redir_pc_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      redir_valid_q <= redir_valid_d;
      epoch_q       <= epoch_d;
      if (redir_valid_d)    state_q <= REDIR;
      else if (out_valid_d) state_q <= HOLD;
      else                  state_q <= IDLE;
      if (live) begin
        out_taken_q    <= taken_d;
        out_misalign_q <= taken_d && target_d[1];
        out_rd_we_q    <= is_jal || is_jalr;
        out_rd_data_q  <= (is_jal || is_jalr) ? (in_pc + XLEN'(4)) : '0;
        // redir_pc changes only when a new redirect is raised, so it is
        // stable for as long as redir_valid is high.
        if (redirect_d) redir_pc_q <= target_d;
      end
    end
  end

  assign epoch        = epoch_q;
  assign out_valid    = out_valid_q;
  assign out_rd_we    = out_rd_we_q;
  assign out_rd_data  = out_rd_data_q;
  assign out_taken    = out_taken_q;
  assign out_misalign = out_misalign_q;
  assign redir_valid  = redir_valid_q;
  assign redir_pc     = redir_pc_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches_q, stat_taken_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else if (live && (in_op != 2'b00)) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (taken_d) stat_taken_q <= stat_taken_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve.
// A transaction-level reference model runs in step with the DUT. Directed
// cases carry literal expectations; a randomized phase follows them.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [1:0]  in_op;
  logic        in_epoch, epoch;
  logic        out_valid, out_ready, out_rd_we, out_taken, out_misalign;
  logic [31:0] out_rd_data;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_op(in_op), .in_epoch(in_epoch), .epoch(epoch),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_we(out_rd_we),
    .out_rd_data(out_rd_data), .out_taken(out_taken), .out_misalign(out_misalign),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        taken;
    logic [31:0] target;
  } res_t;

  // Unsigned less-than, taken from the borrow of a 33-bit subtraction.
  function automatic logic ult(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[32];
  endfunction

  function automatic res_t resolve(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic slt, c;
    // Signed order equals unsigned order once the sign bits are flipped.
    slt = ult(a ^ 32'h8000_0000, b ^ 32'h8000_0000);
    case (f3)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = slt;
      3'b101:  c = !slt;
      3'b110:  c = ult(a, b);
      3'b111:  c = !ult(a, b);
      default: c = 1'b0;
    endcase
    r.taken  = (op == 2'd2) || (op == 2'd3) || ((op == 2'd1) && c);
    r.target = (op == 2'd3) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    return r;
  endfunction

  logic        m_ov, m_rv, m_ep, m_taken, m_mis, m_we;
  logic [31:0] m_rd, m_rpc, m_sb, m_st;

  task automatic model_reset();
    m_ov = 0; m_rv = 0; m_ep = 0; m_taken = 0; m_mis = 0; m_we = 0;
    m_rd = 0; m_rpc = 0; m_sb = 0; m_st = 0;
  endtask

  function automatic logic model_ready();
    return !m_rv && (!m_ov || out_ready);
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    res_t r;
    logic live;
    if (rst) begin
      model_reset();
      return;
    end
    live = in_valid && model_ready() && (in_epoch == m_ep);
    if (m_rv && redir_ready) m_rv = 0;
    if (m_ov && out_ready)   m_ov = 0;
    if (live) begin
      r       = resolve(in_op, in_funct3, in_pc, in_imm, in_rs1, in_rs2);
      m_ov    = 1;
      m_taken = r.taken;
      m_mis   = r.taken && r.target[1];
      m_we    = (in_op[1] == 1'b1);
      m_rd    = m_we ? in_pc + 32'd4 : 32'd0;
      if (in_op != 2'd0) begin
        m_sb++;
        if (r.taken) m_st++;
      end
      if (r.taken && !r.target[1]) begin
        m_rv  = 1;
        m_rpc = r.target;
        m_ep  = !m_ep;
      end
    end
  endtask

  // One cycle: check in_ready, update the model, clock, then compare outputs.
  task automatic step();
    #1;
    if (!rst) check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    model_clock();
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("redir_valid", {31'd0, redir_valid}, {31'd0, m_rv});
    check("epoch", {31'd0, epoch}, {31'd0, m_ep});
    if (m_ov) begin
      check("out_taken", {31'd0, out_taken}, {31'd0, m_taken});
      check("out_misalign", {31'd0, out_misalign}, {31'd0, m_mis});
      check("out_rd_we", {31'd0, out_rd_we}, {31'd0, m_we});
      check("out_rd_data", out_rd_data, m_rd);
    end
    if (m_rv) check("redir_pc", redir_pc, m_rpc);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("stat_branches", stat_branches, m_sb);
    check("stat_taken", stat_taken, m_st);
`endif
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic ep);
    in_valid = 1; in_op = op; in_funct3 = f3; in_pc = pc; in_imm = imm;
    in_rs1 = a; in_rs2 = b; in_epoch = ep;
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h5;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    rst = 1; in_valid = 0; in_pc = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0;
    in_funct3 = 0; in_op = 0; in_epoch = 0; out_ready = 1; redir_ready = 0;
    step(); step();
    // Reset state, literal.
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst out_taken", {31'd0, out_taken}, 32'd0);
    check("rst out_misalign", {31'd0, out_misalign}, 32'd0);
    check("rst out_rd_we", {31'd0, out_rd_we}, 32'd0);
    check("rst out_rd_data", out_rd_data, 32'd0);
    check("rst redir_pc", redir_pc, 32'd0);
    check("rst epoch", {31'd0, epoch}, 32'd0);
    rst = 0;

    // BLT -1 < 1 signed: taken, redirect to 0x120. Fetch stalls for 3 cycles.
    drive(2'b01, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step();
    check("blt taken", {31'd0, out_taken}, 32'd1);
    check("blt redir_valid", {31'd0, redir_valid}, 32'd1);
    check("blt redir_pc", redir_pc, 32'h120);
    check("blt epoch", {31'd0, epoch}, 32'd1);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("held redir_pc", redir_pc, 32'h120);
      check("held in_ready", {31'd0, in_ready}, 32'd0);
    end
    redir_ready = 1;
    step();
    check("redir cleared", {31'd0, redir_valid}, 32'd0);
    redir_ready = 0;
    // Stale-epoch op is dropped.
    drive(2'b01, 3'b000, 32'h400, 32'h8, 32'h3, 32'h3, 1'b0);
    step();
    check("stale dropped", {31'd0, out_valid}, 32'd0);
    // BLTU with the same operands: 0xFFFFFFFF is not below 1 unsigned.
    drive(2'b01, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b1);
    step();
    check("bltu out_valid", {31'd0, out_valid}, 32'd1);
    check("bltu not taken", {31'd0, out_taken}, 32'd0);
    check("bltu no redir", {31'd0, redir_valid}, 32'd0);
    // BGE on equal operands is taken.
    drive(2'b01, 3'b101, 32'h300, 32'h40, 32'h5, 32'h5, 1'b1);
    step();
    check("bge taken", {31'd0, out_taken}, 32'd1);
    check("bge redir_pc", redir_pc, 32'h340);
    idle(); redir_ready = 1;
    step();
    redir_ready = 0;
    // BEQ 5/6 back to back: not taken, full throughput.
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 3'b000, 32'h500 + 32'(4 * i), 32'h10, 32'h5, 32'h6, 1'b0);
      #1 check("beq in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("beq out_valid", {31'd0, out_valid}, 32'd1);
      check("beq not taken", {31'd0, out_taken}, 32'd0);
    end
    // JALR: target (0x1001+4)&~1 = 0x1004, link 0x204.
    drive(2'b11, 3'b000, 32'h200, 32'h4, 32'h1001, 32'h0, 1'b0);
    step();
    check("jalr redir_pc", redir_pc, 32'h1004);
    check("jalr rd_we", {31'd0, out_rd_we}, 32'd1);
    check("jalr rd_data", out_rd_data, 32'h204);
    idle(); redir_ready = 1;
    step();
    redir_ready = 0;
    // Misaligned taken branch: target 0x2.
    drive(2'b01, 3'b000, 32'h0, 32'h2, 32'h7, 32'h7, 1'b1);
    step();
    check("mis misalign", {31'd0, out_misalign}, 32'd1);
    check("mis taken", {31'd0, out_taken}, 32'd1);
    check("mis no redir", {31'd0, redir_valid}, 32'd0);
    check("mis epoch", {31'd0, epoch}, 32'd1);
    // Reset while a redirect is pending.
    drive(2'b10, 3'b000, 32'h40, 32'h100, 32'h0, 32'h0, 1'b1);
    step();
    check("jal redir_valid", {31'd0, redir_valid}, 32'd1);
    idle(); rst = 1;
    step();
    check("rst2 redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst2 out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2 epoch", {31'd0, epoch}, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("rst2 stat_branches", stat_branches, 32'd0);
    check("rst2 stat_taken", stat_taken, 32'd0);
`endif
    rst = 0;

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_op       = 2'($urandom_range(0, 3));
      in_funct3   = 3'($urandom_range(0, 7));
      in_pc       = $urandom;
      in_imm      = $urandom;
      in_rs1      = pick_operand();
      in_rs2      = ($urandom_range(0, 9) < 3) ? in_rs1 : pick_operand();
      in_epoch    = ($urandom_range(0, 9) == 0) ? !m_ep : m_ep;
      out_ready   = ($urandom_range(0, 3) != 0);
      redir_ready = ($urandom_range(0, 1) != 0);
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch/jump resolution unit for the in-order core. Accepts one control-transfer or fall-through op per cycle from issue, performs the equality and signed/unsigned magnitude compares on the operands, and computes taken/target and the link value. Registers the result toward writeback and raises a held redirect to fetch on taken. Implements an epoch bit so wrong-path ops already in flight are discarded after a redirect (static predict-not-taken).

## Interface
- XLEN, 32, operand/PC width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  issue offers an op
- in_ready  out  1  unit can accept this cycle
- in_pc  in  XLEN  PC of op
- in_imm  in  XLEN  sign-extended immediate
- in_rs1, in_rs2  in  XLEN  operands
- in_funct3  in  3  branch condition (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
- in_op  in  2  00 none (fall-through), 01 branch, 10 JAL, 11 JALR
- in_epoch  in  1  epoch tag issued with the op
- epoch  out  1  current epoch; issue tags new ops with it
- out_valid  out  1  registered result valid
- out_ready  in  1  writeback accepts result
- out_rd_we  out  1  link write (JAL/JALR only)
- out_rd_data  out  XLEN  in_pc+4 for JAL/JALR, else 0
- out_taken  out  1  control transfer taken
- out_misalign  out  1  taken target has bit 1 set; no redirect issued
- redir_valid  out  1  redirect request to fetch, held until accepted
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  XLEN  redirect target

## Operation
- in_ready = !redir_valid && (!out_valid || out_ready).
- Accept = in_valid && in_ready. If in_epoch != epoch: op dropped silently, no output, no state change.
- Conditions: eq = rs1==rs2; signed lt via full XLEN two's-complement compare (sign bits differing decides: rs1 negative, rs2 non-negative -> lt=1); unsigned lt plain magnitude. BGE/BGEU = !lt, so equal operands give taken.
- funct3 010/011 on a branch: not taken, no fault.
- Targets: branch/JAL = in_pc+in_imm; JALR = (in_rs1+in_imm) & ~1. Sums wrap modulo 2^XLEN; in_pc+4 wraps too.
- taken = JAL or JALR or (branch and condition true). in_op 00: taken=0, rd_we=0.
- On accepted live op: out_valid<=1 with results. If taken and target[1]==0: redir_valid<=1, redir_pc<=target, epoch toggles. If taken and target[1]==1: out_misalign=1, out_taken=1, no redirect, epoch unchanged.
- out_valid clears when out_ready && out_valid with no new accept; redir_valid clears on redir_valid && redir_ready.
- States: IDLE (nothing held), HOLD (out_valid only), REDIR (redir_valid, out_valid either). REDIR blocks input; returns to IDLE/HOLD on redir_ready.

## Timing
- Latency 1 cycle: accept at edge N -> out_valid, redir_valid, new epoch visible after edge N.
- Throughput 1 op/cycle while not-taken and out_ready=1.
- Taken op: minimum 1 bubble (redirect cycle); in_ready low until redir_ready seen.
- out_ready and accept same cycle: output register reloads, out_valid stays 1.
- redir_ready asserted in same cycle redir_valid rises is consumed on following edge; redir_pc stable while redir_valid=1.
- Reset: out_valid=0, redir_valid=0, out_taken=0, out_misalign=0, out_rd_we=0, out_rd_data=0, redir_pc=0, epoch=0, counters=0. rst mid-redirect drops the pending redirect; rst overrides all same-cycle events.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: adds outputs stat_branches (32) and stat_taken (32); stat_branches increments on every accepted live branch/JAL/JALR, stat_taken on each with taken=1; wrap at 2^32; cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- BLT rs1=0xFFFFFFFF, rs2=0x00000001, pc=0x100, imm=0x20 -> taken, redir_pc=0x120, epoch 0->1; BLTU same operands -> not taken, no redirect.
- BGE equal operands 0x5/0x5 -> taken; BEQ 0x5/0x6 -> not taken, back-to-back accepts with in_ready held 1.
- JALR rs1=0x1001, imm=0x4, pc=0x200 -> redir_pc=0x1004, out_rd_we=1, out_rd_data=0x204.
- Taken branch with redir_ready low 3 cycles -> redir_valid/redir_pc held, in_ready=0; op with stale in_epoch=0 afterward -> dropped, no out_valid.
- Branch pc=0x0, imm=0x2 taken -> out_misalign=1, redir_valid=0, epoch unchanged.
- rst asserted while redir_valid=1 -> next cycle redir_valid=0, out_valid=0, epoch=0 (stats counters 0 with BRANCH_RESOLVE_STATS_EN).
